// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction controller.
package atm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PIN_ENTRY,
        TRANSACCION,
        FIN,
        BLOQUEADO
    } atm_state_t;

    localparam int unsigned PIN_DIGITS     = 4;
    localparam logic        TRANS_DEPOSITO = 1'b0;
    localparam logic        TRANS_RETIRO   = 1'b1;

endpackage

// File: rtl/atm_controller_strobe_edge.sv
// Registered copy of a strobe plus a rising-edge pulse; a strobe held for
// several cycles produces a single pulse.
module strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic strobe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/atm_controller.sv
// ATM transaction controller: PIN entry with attempt lockout, one deposit or
// withdrawal per card. Define ATM_WITHDRAW_LIMIT_EN to enforce MAX_RETIRO.
module atm_controller
    import atm_pkg::*;
#(
    parameter int unsigned           BALANCE_W    = 64,
    parameter logic [BALANCE_W-1:0]  BALANCE_INIT = 64'd500000,
    parameter int unsigned           MAX_INTENTOS = 3,
    parameter logic [31:0]           MAX_RETIRO   = 32'd1000000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 TARJETA_RECIBIDA,
    input  logic [15:0]          PIN,
    input  logic [3:0]           DIGITO,
    input  logic                 DIGITO_STB,
    input  logic                 TIPO_TRANS,
    input  logic [31:0]          MONTO,
    input  logic                 MONTO_STB,
    output logic [BALANCE_W-1:0] BALANCE,
    output logic                 BALANCE_ACTUALIZADO,
    output logic                 ENTREGAR_DINERO,
    output logic                 FONDOS_INSUFICIENTES,
    output logic                 PIN_INCORRECTO,
    output logic                 ADVERTENCIA,
    output logic                 BLOQUEO
);

`ifdef ATM_WITHDRAW_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int unsigned ATT_W   = $clog2(MAX_INTENTOS + 1);
    localparam int unsigned CNT_W   = $clog2(PIN_DIGITS);
    // Only the first three digits are stored; the fourth is compared live.
    localparam int unsigned SHIFT_W = 4 * (PIN_DIGITS - 1);

    atm_state_t           state;
    logic [ATT_W-1:0]     attempts;
    logic [ATT_W-1:0]     att_next;
    logic [CNT_W-1:0]     dig_cnt;
    logic [SHIFT_W-1:0]   shift_q;
    logic                 digit_rise;
    logic                 monto_rise;
    logic [BALANCE_W-1:0] monto_ext;
    logic [BALANCE_W:0]   dep_sum;
    logic                 wd_reject;
    logic                 pin_match;

    strobe_edge u_digit_edge (
        .clk    (CLK),
        .rst    (RESET),
        .strobe (DIGITO_STB),
        .rise   (digit_rise)
    );

    strobe_edge u_monto_edge (
        .clk    (CLK),
        .rst    (RESET),
        .strobe (MONTO_STB),
        .rise   (monto_rise)
    );

    always_comb begin
        monto_ext = BALANCE_W'(MONTO);
        dep_sum   = {1'b0, BALANCE} + {1'b0, monto_ext};
        wd_reject = (monto_ext > BALANCE) || (LIMIT_EN && (MONTO > MAX_RETIRO));
        pin_match = ({shift_q, DIGITO} == PIN);
        att_next  = attempts + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                <= IDLE;
            BALANCE              <= BALANCE_INIT;
            attempts             <= '0;
            dig_cnt              <= '0;
            shift_q              <= '0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
        end else begin
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            case (state)
                IDLE: begin
                    if (TARJETA_RECIBIDA) begin
                        state   <= PIN_ENTRY;
                        dig_cnt <= '0;
                    end
                end
                PIN_ENTRY: begin
                    // Card removal keeps attempts and ADVERTENCIA so lockout cannot be dodged.
                    if (!TARJETA_RECIBIDA) begin
                        state   <= IDLE;
                        dig_cnt <= '0;
                        shift_q <= '0;
                    end else if (digit_rise) begin
                        shift_q <= {shift_q[SHIFT_W-5:0], DIGITO};
                        if (dig_cnt == CNT_W'(PIN_DIGITS - 1)) begin
                            dig_cnt <= '0;
                            if (pin_match) begin
                                attempts    <= '0;
                                ADVERTENCIA <= 1'b0;
                                state       <= TRANSACCION;
                            end else begin
                                PIN_INCORRECTO <= 1'b1;
                                attempts       <= att_next;
                                if (att_next == ATT_W'(MAX_INTENTOS)) begin
                                    BLOQUEO     <= 1'b1;
                                    ADVERTENCIA <= 1'b0;
                                    state       <= BLOQUEADO;
                                end else if (att_next == ATT_W'(MAX_INTENTOS - 1)) begin
                                    ADVERTENCIA <= 1'b1;
                                end
                            end
                        end else begin
                            dig_cnt <= dig_cnt + 1'b1;
                        end
                    end
                end
                TRANSACCION: begin
                    if (!TARJETA_RECIBIDA) begin
                        state <= IDLE;
                    end else if (monto_rise) begin
                        if (TIPO_TRANS == TRANS_DEPOSITO) begin
                            BALANCE             <= dep_sum[BALANCE_W] ? '1 : dep_sum[BALANCE_W-1:0];
                            BALANCE_ACTUALIZADO <= 1'b1;
                            state               <= FIN;
                        end else if (wd_reject) begin
                            FONDOS_INSUFICIENTES <= 1'b1;
                        end else begin
                            BALANCE             <= BALANCE - monto_ext;
                            BALANCE_ACTUALIZADO <= 1'b1;
                            ENTREGAR_DINERO     <= 1'b1;
                            state               <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (!TARJETA_RECIBIDA) begin
                        state <= IDLE;
                    end
                end
                BLOQUEADO: begin
                    BLOQUEO <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_controller.sv
// Scoreboard bench for atm_controller: each driven cycle pushes the expected
// outputs, which are compared on the falling edge after the next rising edge.
module tb_atm_controller;

`ifdef ATM_WITHDRAW_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif
    localparam logic [15:0] CARD_PIN = 16'h6575;
    localparam logic [3:0]  P_NONE = 4'b0000;
    localparam logic [3:0]  P_PIN  = 4'b0001;
    localparam logic [3:0]  P_NSF  = 4'b0010;
    localparam logic [3:0]  P_CASH = 4'b0100;
    localparam logic [3:0]  P_BAL  = 4'b1000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        TARJETA_RECIBIDA;
    logic [15:0] PIN;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [63:0] BALANCE;
    logic        BALANCE_ACTUALIZADO;
    logic        ENTREGAR_DINERO;
    logic        FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO;
    logic        ADVERTENCIA;
    logic        BLOQUEO;

    atm_controller #(
        .MAX_RETIRO (32'd1000)
    ) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .PIN                  (PIN),
        .DIGITO               (DIGITO),
        .DIGITO_STB           (DIGITO_STB),
        .TIPO_TRANS           (TIPO_TRANS),
        .MONTO                (MONTO),
        .MONTO_STB            (MONTO_STB),
        .BALANCE              (BALANCE),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [3:0]  p;
        logic [63:0] bal;
        logic        adv;
        logic        blq;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_bal;
    int unsigned m_att;
    logic        m_adv;
    logic        m_blq;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] p);
        exp_t e;
        e.tag = tag;
        e.p   = p;
        e.bal = m_bal;
        e.adv = m_adv;
        e.blq = m_blq;
        q.push_back(e);
    endtask

    // Items pushed on one falling edge are due on the next falling edge.
    initial begin
        logic due;
        exp_t e;
        forever begin
            @(posedge CLK);
            due = (q.size() > 0);
            @(negedge CLK);
            if (due) begin
                e = q.pop_front();
                check_val({e.tag, "/pulse"}, 64'({BALANCE_ACTUALIZADO, ENTREGAR_DINERO,
                          FONDOS_INSUFICIENTES, PIN_INCORRECTO}), 64'(e.p));
                check_val({e.tag, "/bal"}, BALANCE, e.bal);
                check_val({e.tag, "/lvl"}, 64'({ADVERTENCIA, BLOQUEO}), 64'({e.adv, e.blq}));
            end
        end
    end

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESET = 1'b1;
        m_bal = 64'd500000;
        m_att = 0;
        m_adv = 1'b0;
        m_blq = 1'b0;
        push_exp(tag, P_NONE);
        @(negedge CLK);
        RESET = 1'b0;
        push_exp(tag, P_NONE);
    endtask

    task automatic card_set(input string tag, input logic v);
        @(negedge CLK);
        TARJETA_RECIBIDA = v;
        push_exp(tag, P_NONE);
    endtask

    task automatic strobe_digit(input string tag, input logic [3:0] d, input int unsigned hold,
                                input logic [3:0] p_first);
        @(negedge CLK);
        DIGITO     = d;
        DIGITO_STB = 1'b1;
        push_exp(tag, p_first);
        for (int unsigned i = 1; i < hold; i++) begin
            @(negedge CLK);
            push_exp(tag, P_NONE);
        end
        @(negedge CLK);
        DIGITO_STB = 1'b0;
        push_exp(tag, P_NONE);
    endtask

    task automatic enter_pin(input string tag, input logic [15:0] code, input int unsigned hold0);
        logic [3:0] p;
        for (int unsigned i = 0; i < 3; i++) begin
            strobe_digit(tag, code[15-4*i -: 4], (i == 0) ? hold0 : 1, P_NONE);
        end
        if (code == CARD_PIN) begin
            m_att = 0;
            m_adv = 1'b0;
            p     = P_NONE;
        end else begin
            m_att++;
            p = P_PIN;
            if (m_att == 3) begin
                m_blq = 1'b1;
                m_adv = 1'b0;
            end else if (m_att == 2) begin
                m_adv = 1'b1;
            end
        end
        strobe_digit(tag, code[3:0], 1, p);
    endtask

    task automatic amount(input string tag, input logic tipo, input logic [31:0] m, input logic live);
        logic [3:0]  p;
        logic [64:0] s;
        p = P_NONE;
        if (live) begin
            if (tipo == 1'b0) begin
                s     = {1'b0, m_bal} + {33'b0, m};
                m_bal = s[64] ? '1 : s[63:0];
                p     = P_BAL;
            end else if ((64'(m) > m_bal) || (LIM && (m > 32'd1000))) begin
                p = P_NSF;
            end else begin
                m_bal = m_bal - 64'(m);
                p     = P_BAL | P_CASH;
            end
        end
        @(negedge CLK);
        TIPO_TRANS = tipo;
        MONTO      = m;
        MONTO_STB  = 1'b1;
        push_exp(tag, p);
        @(negedge CLK);
        MONTO_STB = 1'b0;
        push_exp(tag, P_NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        RESET            = 1'b1;
        TARJETA_RECIBIDA = 1'b0;
        PIN              = CARD_PIN;
        DIGITO           = 4'd0;
        DIGITO_STB       = 1'b0;
        TIPO_TRANS       = 1'b0;
        MONTO            = 32'd0;
        MONTO_STB        = 1'b0;
        do_reset("reset");

        // 1: correct PIN, oversize withdrawal rejected, then a valid one
        card_set("t1_card", 1'b1);
        enter_pin("t1_pin", 16'h6575, 1);
        amount("t1_nsf", 1'b1, 32'd99999999, 1'b1);
        amount("t1_wd", 1'b1, 32'd272727, 1'b1);

        // 2: deposit; digits ignored in TRANSACCION, amounts ignored in FIN
        card_set("t2_out", 1'b0);
        card_set("t2_in", 1'b1);
        enter_pin("t2_pin", 16'h6575, 1);
        strobe_digit("t2_dig_ign", 4'd1, 1, P_NONE);
        amount("t2_dep", 1'b0, 32'd272727, 1'b1);
        amount("t2_fin_ign", 1'b0, 32'd5, 1'b0);

        // 3: amount ignored in PIN_ENTRY, three wrong PINs lock the machine
        card_set("t3_out", 1'b0);
        card_set("t3_in", 1'b1);
        amount("t3_mnt_ign", 1'b0, 32'd5, 1'b0);
        enter_pin("t3_bad1", 16'h6574, 1);
        enter_pin("t3_bad2", 16'h6586, 1);
        enter_pin("t3_bad3", 16'h5700, 1);

        // 4: locked machine ignores everything until reset
        strobe_digit("t4_lk_dig", 4'd6, 1, P_NONE);
        amount("t4_lk_mnt", 1'b1, 32'd10, 1'b0);
        card_set("t4_lk_out", 1'b0);
        card_set("t4_lk_in", 1'b1);
        do_reset("t4_rst");
        enter_pin("t4_pin", 16'h6575, 1);
        amount("t4_wd_all", 1'b1, 32'd500000, 1'b1);
        card_set("t4_out", 1'b0);

        // 5: attempt count survives card removal; partial entry does not
        card_set("t5_in", 1'b1);
        enter_pin("t5_bad1", 16'h1111, 1);
        enter_pin("t5_bad2", 16'h2222, 1);
        card_set("t5_out", 1'b0);
        card_set("t5_in2", 1'b1);
        enter_pin("t5_bad3", 16'h3333, 1);
        do_reset("t5_rst");
        strobe_digit("t5_part", 4'd6, 1, P_NONE);
        strobe_digit("t5_part", 4'd5, 1, P_NONE);
        card_set("t5_pout", 1'b0);
        card_set("t5_pin", 1'b1);
        enter_pin("t5_pin_ok", 16'h6575, 1);
        @(negedge CLK);
        TARJETA_RECIBIDA = 1'b0;
        TIPO_TRANS       = 1'b0;
        MONTO            = 32'd1;
        MONTO_STB        = 1'b1;
        push_exp("t5_prio", P_NONE);
        @(negedge CLK);
        MONTO_STB = 1'b0;
        push_exp("t5_prio", P_NONE);
        card_set("t5_in3", 1'b1);

        // 6: held digit strobe counts once; withdrawal limit when enabled
        enter_pin("t6_hold", 16'h6575, 3);
        amount("t6_limit", 1'b1, 32'd2000, 1'b1);

        repeat (3) @(negedge CLK);
        check_val("drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_controller.md
Name: atm_controller

Overview:
Synchronous ATM transaction controller; the responder for the card/PIN/amount stimulus interface driven by the team's ATM bench.
- Accepts a 4-digit PIN one strobed digit at a time and compares it with the card PIN.
- Tracks failed attempts with warning and lockout.
- Executes one deposit or withdrawal against an internal balance register.
- Reports results as registered pulses and levels.

Parameters:
BALANCE_W, 64, balance register width
BALANCE_INIT, 64'd500000, balance loaded at reset
MAX_INTENTOS, 3, failed PIN attempts that cause BLOQUEO
MAX_RETIRO, 32'd1000000, per-transaction withdrawal cap (used only with ATM_WITHDRAW_LIMIT_EN)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
TARJETA_RECIBIDA  input  1  card present (level)
PIN  input  16  card PIN, 4 BCD digits, first digit in [15:12]
DIGITO  input  4  keypad digit
DIGITO_STB  input  1  digit strobe; may be held several cycles
TIPO_TRANS  input  1  0 = deposit, 1 = withdrawal
MONTO  input  32  transaction amount
MONTO_STB  input  1  amount strobe; may be held several cycles
BALANCE  output  BALANCE_W  current balance
BALANCE_ACTUALIZADO  output  1  1-cycle pulse: balance changed
ENTREGAR_DINERO  output  1  1-cycle pulse: dispense cash
FONDOS_INSUFICIENTES  output  1  1-cycle pulse: withdrawal rejected
PIN_INCORRECTO  output  1  1-cycle pulse: wrong PIN
ADVERTENCIA  output  1  level: one attempt remaining
BLOQUEO  output  1  level: machine locked

Behaviour:
- Reset:
  - state = IDLE, BALANCE = BALANCE_INIT, attempts = 0, digit count = 0.
  - All pulse outputs, ADVERTENCIA and BLOQUEO = 0.
  - RESET mid-operation aborts any entry or transaction; it is the only exit from BLOQUEADO.
- Strobes:
  - Each strobe is rising-edge detected against a registered copy.
  - A strobe held N cycles counts as one event.
  - All outputs are registered. A response appears on the clock edge that samples the rising strobe and lasts exactly one cycle.
- States:
  - IDLE: wait for TARJETA_RECIBIDA=1, then go to PIN_ENTRY with digit count = 0.
  - PIN_ENTRY:
    - Each DIGITO_STB edge shifts DIGITO into a 16-bit register, first digit at MSB.
    - On the 4th digit, compare {shift[11:0], DIGITO} with PIN in the same cycle.
    - Match: attempts = 0, ADVERTENCIA = 0, go to TRANSACCION.
    - Mismatch: pulse PIN_INCORRECTO, attempts+1, count = 0.
    - attempts == MAX_INTENTOS-1 sets ADVERTENCIA.
    - attempts == MAX_INTENTOS sets BLOQUEO, clears ADVERTENCIA, goes to BLOQUEADO.
    - MONTO_STB is ignored in this state.
  - TRANSACCION: on a MONTO_STB edge, sample TIPO_TRANS and MONTO.
    - Deposit: BALANCE += MONTO, saturating at all-ones; pulse BALANCE_ACTUALIZADO; go to FIN.
    - Withdrawal with MONTO > BALANCE: pulse FONDOS_INSUFICIENTES, BALANCE unchanged, stay in TRANSACCION (retry allowed).
    - Withdrawal otherwise: BALANCE -= MONTO; pulse BALANCE_ACTUALIZADO and ENTREGAR_DINERO together; go to FIN.
    - DIGITO_STB is ignored in this state.
  - FIN: all strobes ignored; wait for TARJETA_RECIBIDA=0.
  - BLOQUEADO: all inputs ignored, including card removal; BLOQUEO held at 1.
- Card removal (TARJETA_RECIBIDA=0) in PIN_ENTRY, TRANSACCION or FIN:
  - Go to IDLE next edge and discard the partial PIN.
  - The attempt counter and ADVERTENCIA are kept, so lockout cannot be bypassed by pulling the card.
- Simultaneous events:
  - Card removal takes priority over a strobe in the same cycle.
  - RESET takes priority over everything.
- Width rule: MONTO is zero-extended to BALANCE_W; compare and subtract are unsigned.

Optional Feature:
ATM_WITHDRAW_LIMIT_EN
- Defined: a withdrawal with MONTO > MAX_RETIRO is rejected exactly like insufficient funds (FONDOS_INSUFICIENTES pulse, stay in TRANSACCION), even when the balance suffices.
- Undefined: only the balance check applies; MAX_RETIRO is unused.

Decomposition:
- Package atm_pkg:
  - state enum (IDLE, PIN_ENTRY, TRANSACCION, FIN, BLOQUEADO)
  - PIN_DIGITS = 4
  - TRANS_DEPOSITO = 1'b0, TRANS_RETIRO = 1'b1
- Sub-module strobe_edge: register plus rising-edge pulse, reset to 0. Instantiated twice, for DIGITO_STB and MONTO_STB.

Test Plan:
1. Reset, card in, PIN=16'h6575, digits 6,5,7,5 -> no PIN_INCORRECTO, state TRANSACCION. TIPO_TRANS=1, MONTO=99999999 -> FONDOS_INSUFICIENTES 1 cycle, BALANCE=500000. Then MONTO=272727 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO 1 cycle, BALANCE=227273.
2. Card out/in, correct PIN, TIPO_TRANS=0, MONTO=272727 -> BALANCE_ACTUALIZADO pulse, BALANCE=500000, ENTREGAR_DINERO=0.
3. Digits 6,5,7,4 -> PIN_INCORRECTO pulse. Digits 6,5,8,6 -> pulse and ADVERTENCIA=1. Digits 5,7,0,0 -> pulse, BLOQUEO=1, ADVERTENCIA=0.
4. While locked: digit/amount strobes and card removal -> no output changes. RESET 1 cycle -> BLOQUEO=0, BALANCE=500000, then 6,5,7,5 is accepted.
5. Two wrong PINs, card out/in, one more wrong PIN -> BLOQUEO=1 (attempt count kept). Separately: 2 digits, card out/in, 6,5,7,5 -> accepted (partial entry discarded).
6. DIGITO_STB held 3 cycles with DIGITO=6 -> counted as one digit. With ATM_WITHDRAW_LIMIT_EN, MAX_RETIRO=1000, withdraw 2000 with balance 500000 -> FONDOS_INSUFICIENTES.
